// File: rtl/stack_cpu_core_if.sv
// Unified 32x8 memory bus between the stack CPU core (master) and its memory (slave).
interface stack_cpu_core_if;
  logic [4:0] address;
  logic       write_enable;
  logic [7:0] write_data;
  logic [7:0] read_data;

  modport master (output address, output write_enable, output write_data, input read_data);
  modport slave  (input address, input write_enable, input write_data, output read_data);
endinterface

// File: rtl/stack_cpu_core.sv
// Multi-cycle 8-bit stack-machine core (FETCH/DECODE/EXEC) mastering a 32x8 unified memory.
// Defining STACK_FAULT_EN adds overflow/underflow detection with a sticky fault and HALT state.
module stack_cpu_core #(
  parameter int STACK_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  stack_cpu_core_if.master             bus,
  output logic [4:0]                   pc,
  output logic [7:0]                   tos,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         fault
);

  localparam int IW  = $clog2(STACK_DEPTH);
  localparam int SPW = IW + 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

`ifdef STACK_FAULT_EN
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
`else
  typedef enum logic [1:0] {FETCH, DECODE, EXEC} state_t;
`endif

  state_t         state;
  state_t         state_next;
  logic [7:0]     ir;
  logic [7:0]     stack [STACK_DEPTH];
  logic [2:0]     op;
  logic [4:0]     target;
  logic [IW-1:0]  sp_idx;
  logic [IW-1:0]  tos_idx;
  logic [IW-1:0]  nos_idx;
  logic [7:0]     tos_raw;
  logic [7:0]     nos_raw;
  logic [7:0]     alu_result;
  logic [SPW-1:0] sp_inc;
  logic [SPW-1:0] sp_dec;
  logic           stack_fault;

  assign op      = ir[7:5];
  assign target  = ir[4:0];
  assign sp_idx  = sp[IW-1:0];
  assign tos_idx = sp_idx - IW'(1);
  assign nos_idx = sp_idx - IW'(2);
  assign tos_raw = stack[tos_idx];
  assign nos_raw = stack[nos_idx];
  assign tos     = (sp == '0) ? 8'h00 : tos_raw;

  // Without fault checking the pointer wraps mod STACK_DEPTH; with it, sp may legally reach STACK_DEPTH.
`ifdef STACK_FAULT_EN
  assign sp_inc = sp + SPW'(1);
  assign sp_dec = sp - SPW'(1);

  always_comb begin
    stack_fault = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND: stack_fault = (sp < SPW'(2));
      OP_NOT, OP_POP, OP_JZ:  stack_fault = (sp == '0);
      OP_PUSH:                stack_fault = (sp == SPW'(STACK_DEPTH));
      default:                stack_fault = 1'b0;
    endcase
  end
`else
  assign sp_inc      = {1'b0, sp_idx + IW'(1)};
  assign sp_dec      = {1'b0, sp_idx - IW'(1)};
  assign stack_fault = 1'b0;
  assign fault       = 1'b0;
`endif

  always_comb begin
    case (op)
      OP_SUB:  alu_result = nos_raw - tos_raw;
      OP_AND:  alu_result = nos_raw & tos_raw;
      default: alu_result = nos_raw + tos_raw;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Bus outputs decode only registered state and ir, so write_enable holds steady across the negedge.
  always_comb begin
    state_next       = state;
    bus.address      = target;
    bus.write_enable = 1'b0;
    bus.write_data   = 8'h00;
    case (state)
      FETCH: begin
        bus.address = pc;
        state_next  = DECODE;
      end
`ifdef STACK_FAULT_EN
      DECODE: state_next = stack_fault ? HALT : EXEC;
      HALT:   state_next = HALT;
`else
      DECODE: state_next = EXEC;
`endif
      EXEC: begin
        state_next = FETCH;
        if (op == OP_POP) begin
          bus.write_enable = 1'b1;
          bus.write_data   = tos_raw;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= 5'd0;
      ir <= 8'h00;
      sp <= '0;
`ifdef STACK_FAULT_EN
      fault <= 1'b0;
`endif
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= 8'h00;
    end else begin
      case (state)
        FETCH: begin
          ir <= bus.read_data;
          pc <= pc + 5'd1;
        end
`ifdef STACK_FAULT_EN
        DECODE: if (stack_fault) fault <= 1'b1;
`endif
        EXEC: begin
          case (op)
            OP_ADD, OP_SUB, OP_AND: begin
              stack[nos_idx] <= alu_result;
              sp             <= sp_dec;
            end
            OP_NOT: stack[tos_idx] <= ~tos_raw;
            OP_PUSH: begin
              stack[sp_idx] <= bus.read_data;
              sp            <= sp_inc;
            end
            OP_POP: sp <= sp_dec;
            OP_JMP: pc <= target;
            OP_JZ:  if (tos_raw == 8'h00) pc <= target;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_cpu_core.sv
// Scoreboarded bench for stack_cpu_core: behavioural 32x8 memory committing writes on negedge.
module tb_stack_cpu_core;
  localparam int STACK_DEPTH = 8;
  localparam int SPW = $clog2(STACK_DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           load_req = 1'b0;
  logic [4:0]     pc;
  logic [7:0]     tos;
  logic [SPW-1:0] sp;
  logic           fault;
  logic [7:0]     mem [32];
  logic [7:0]     image [32];
  logic [12:0]    exp_q [$];
  logic [12:0]    exp_item;
  int             total = 0;
  int             passed = 0;
  int             write_count = 0;
  int             base;

  stack_cpu_core_if bus ();
  assign bus.read_data = mem[bus.address];

  stack_cpu_core #(.STACK_DEPTH(STACK_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pc(pc), .tos(tos), .sp(sp), .fault(fault)
  );

  always #5 clk = ~clk;

  // Memory model and scoreboard: every committed write must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.write_enable) begin
      write_count++;
      total++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_write got addr=%0d data=%h want no write", bus.address, bus.write_data);
      end else begin
        exp_item = exp_q.pop_front();
        if ({bus.address, bus.write_data} !== exp_item)
          $display("[TB] FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                   bus.address, bus.write_data, exp_item[12:8], exp_item[7:0]);
        else passed++;
      end
      mem[bus.address] = bus.write_data;
    end else if (load_req) begin
      for (int i = 0; i < 32; i++) mem[i] = image[i];
    end
  end

  task automatic clear_image;
    for (int i = 0; i < 32; i++) image[i] = 8'h00;
  endtask

  task automatic do_reset;
    load_req = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clear_image();
    load_req = 1'b1;
    rst = 1'b1;
    #1;
    total++; if (bus.address !== 5'd0) $display("[TB] FAIL rst_address got=%0d want=0", bus.address); else passed++;
    total++; if (bus.write_enable !== 1'b0) $display("[TB] FAIL rst_we got=%b want=0", bus.write_enable); else passed++;
    total++; if (bus.write_data !== 8'h00) $display("[TB] FAIL rst_wdata got=%h want=00", bus.write_data); else passed++;
    total++; if (pc !== 5'd0) $display("[TB] FAIL rst_pc got=%0d want=0", pc); else passed++;
    total++; if (sp !== '0) $display("[TB] FAIL rst_sp got=%0d want=0", sp); else passed++;
    total++; if (tos !== 8'h00) $display("[TB] FAIL rst_tos got=%h want=00", tos); else passed++;
    total++; if (fault !== 1'b0) $display("[TB] FAIL rst_fault got=%b want=0", fault); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load_req = 1'b0;
  endtask

  // push29, push29, add, then jmp7 / jz12 / push30 / sub / jz15.
  task automatic test_push_add;
    clear_image();
    image[0] = 8'h9D; image[1] = 8'h9D; image[2] = 8'h00; image[3] = 8'hC7;
    image[7] = 8'hEC; image[8] = 8'h9E; image[9] = 8'h20; image[10] = 8'hEF;
    image[29] = 8'd8; image[30] = 8'd16;
    do_reset();
    base = write_count;
    run(3);
    total++; if (sp !== 4'd1 || tos !== 8'd8) $display("[TB] FAIL push1 got sp=%0d tos=%0d want sp=1 tos=8", sp, tos); else passed++;
    run(6);
    total++; if (sp !== 4'd1) $display("[TB] FAIL add_sp got=%0d want=1", sp); else passed++;
    total++; if (tos !== 8'd16) $display("[TB] FAIL add_tos got=%0d want=16", tos); else passed++;
    total++; if (pc !== 5'd3) $display("[TB] FAIL add_pc got=%0d want=3", pc); else passed++;
    total++; if (write_count != base) $display("[TB] FAIL add_nowrite got=%0d want=0", write_count - base); else passed++;
  endtask

  task automatic test_jumps;
    run(3);
    total++; if (pc !== 5'd7) $display("[TB] FAIL jmp_pc got=%0d want=7", pc); else passed++;
    run(3);
    total++; if (pc !== 5'd8 || sp !== 4'd1 || tos !== 8'd16) $display("[TB] FAIL jz_nz got pc=%0d sp=%0d tos=%0d want pc=8 sp=1 tos=16", pc, sp, tos); else passed++;
    run(3);
    total++; if (sp !== 4'd2 || tos !== 8'd16) $display("[TB] FAIL push30 got sp=%0d tos=%0d want sp=2 tos=16", sp, tos); else passed++;
    run(3);
    total++; if (sp !== 4'd1 || tos !== 8'd0 || pc !== 5'd10) $display("[TB] FAIL sub got sp=%0d tos=%0d pc=%0d want sp=1 tos=0 pc=10", sp, tos, pc); else passed++;
    run(3);
    total++; if (pc !== 5'd15 || sp !== 4'd1) $display("[TB] FAIL jz_z got pc=%0d sp=%0d want pc=15 sp=1", pc, sp); else passed++;
  endtask

  // push28, push27, and, not, pop31.
  task automatic test_logic_pop;
    clear_image();
    image[0] = 8'h9C; image[1] = 8'h9B; image[2] = 8'h40; image[3] = 8'h60; image[4] = 8'hBF;
    image[28] = 8'hAA; image[27] = 8'h66;
    do_reset();
    run(6);
    total++; if (sp !== 4'd2 || tos !== 8'h66) $display("[TB] FAIL push27 got sp=%0d tos=%h want sp=2 tos=66", sp, tos); else passed++;
    run(3);
    total++; if (sp !== 4'd1 || tos !== 8'h22) $display("[TB] FAIL and got sp=%0d tos=%h want sp=1 tos=22", sp, tos); else passed++;
    run(3);
    total++; if (tos !== 8'hDD) $display("[TB] FAIL not got=%h want=dd", tos); else passed++;
    base = write_count;
    exp_q.push_back({5'd31, 8'hDD});
    run(1);
    total++; if (bus.write_enable !== 1'b0 || bus.address !== 5'd31) $display("[TB] FAIL pop_decode got we=%b addr=%0d want we=0 addr=31", bus.write_enable, bus.address); else passed++;
    run(1);
    total++; if (bus.write_enable !== 1'b1 || bus.address !== 5'd31 || bus.write_data !== 8'hDD)
      $display("[TB] FAIL pop_exec got we=%b addr=%0d data=%h want we=1 addr=31 data=dd", bus.write_enable, bus.address, bus.write_data); else passed++;
    run(1);
    total++; if (bus.write_enable !== 1'b0) $display("[TB] FAIL pop_after_we got=%b want=0", bus.write_enable); else passed++;
    total++; if (sp !== 4'd0 || tos !== 8'h00) $display("[TB] FAIL pop_sp got sp=%0d tos=%h want sp=0 tos=00", sp, tos); else passed++;
    total++; if (mem[31] !== 8'hDD) $display("[TB] FAIL pop_mem got=%h want=dd", mem[31]); else passed++;
    total++; if (write_count - base != 1) $display("[TB] FAIL pop_pulses got=%0d want=1", write_count - base); else passed++;
  endtask

  task automatic test_overflow;
    clear_image();
    for (int i = 0; i < STACK_DEPTH + 1; i++) begin
      image[i] = 8'h80 | 8'(20 + i);
      image[20 + i] = 8'(i + 1);
    end
    do_reset();
    run(3 * STACK_DEPTH);
`ifdef STACK_FAULT_EN
    total++; if (sp !== 4'd8 || tos !== 8'd8) $display("[TB] FAIL full got sp=%0d tos=%0d want sp=8 tos=8", sp, tos); else passed++;
    run(3);
    total++; if (fault !== 1'b1 || sp !== 4'd8 || pc !== 5'd9) $display("[TB] FAIL ovf got fault=%b sp=%0d pc=%0d want fault=1 sp=8 pc=9", fault, sp, pc); else passed++;
    run(6);
    total++; if (pc !== 5'd9 || sp !== 4'd8 || bus.write_enable !== 1'b0) $display("[TB] FAIL halt got pc=%0d sp=%0d we=%b want pc=9 sp=8 we=0", pc, sp, bus.write_enable); else passed++;
`else
    total++; if (sp !== 4'd0 || tos !== 8'd0) $display("[TB] FAIL full got sp=%0d tos=%0d want sp=0 tos=0", sp, tos); else passed++;
    run(3);
    total++; if (sp !== 4'd1 || tos !== 8'd9 || pc !== 5'd9) $display("[TB] FAIL wrap got sp=%0d tos=%0d pc=%0d want sp=1 tos=9 pc=9", sp, tos, pc); else passed++;
    total++; if (fault !== 1'b0) $display("[TB] FAIL wrap_fault got=%b want=0", fault); else passed++;
`endif
  endtask

  // jmp31 then a push at 31: pc wraps to 0; then a pop on an empty stack.
  task automatic test_pc_wrap_empty_pop;
    clear_image();
    image[0] = 8'hDF; image[31] = 8'h9E; image[30] = 8'h5A;
    do_reset();
    run(3);
    total++; if (pc !== 5'd31) $display("[TB] FAIL jmp31 got=%0d want=31", pc); else passed++;
    run(1);
    total++; if (pc !== 5'd0) $display("[TB] FAIL pc_wrap got=%0d want=0", pc); else passed++;
    run(2);
    total++; if (sp !== 4'd1 || tos !== 8'h5A) $display("[TB] FAIL push_at31 got sp=%0d tos=%h want sp=1 tos=5a", sp, tos); else passed++;
    clear_image();
    image[0] = 8'hB9; image[25] = 8'h33;
    do_reset();
    base = write_count;
`ifdef STACK_FAULT_EN
    run(3);
    total++; if (fault !== 1'b1 || pc !== 5'd1) $display("[TB] FAIL unf got fault=%b pc=%0d want fault=1 pc=1", fault, pc); else passed++;
    run(3);
    total++; if (pc !== 5'd1 || mem[25] !== 8'h33 || write_count != base)
      $display("[TB] FAIL unf_halt got pc=%0d mem=%h writes=%0d want pc=1 mem=33 writes=0", pc, mem[25], write_count - base); else passed++;
`else
    exp_q.push_back({5'd25, 8'h00});
    run(3);
    total++; if (sp !== 4'd7 || fault !== 1'b0 || pc !== 5'd1) $display("[TB] FAIL empty_pop got sp=%0d fault=%b pc=%0d want sp=7 fault=0 pc=1", sp, fault, pc); else passed++;
    total++; if (mem[25] !== 8'h00) $display("[TB] FAIL empty_pop_mem got=%h want=00", mem[25]); else passed++;
`endif
  endtask

  // push29, pop24; reset lands inside the pop EXEC before its negedge.
  task automatic test_reset_mid_pop;
    clear_image();
    image[0] = 8'h9D; image[1] = 8'hB8; image[29] = 8'h77; image[24] = 8'h11;
    do_reset();
    base = write_count;
    run(5);
    total++; if (bus.write_enable !== 1'b1 || bus.address !== 5'd24 || bus.write_data !== 8'h77)
      $display("[TB] FAIL mid_exec got we=%b addr=%0d data=%h want we=1 addr=24 data=77", bus.write_enable, bus.address, bus.write_data); else passed++;
    rst = 1'b1;
    #1;
    total++; if (bus.address !== 5'd0 || bus.write_enable !== 1'b0) $display("[TB] FAIL abort_bus got addr=%0d we=%b want addr=0 we=0", bus.address, bus.write_enable); else passed++;
    total++; if (pc !== 5'd0 || sp !== '0) $display("[TB] FAIL abort_regs got pc=%0d sp=%0d want pc=0 sp=0", pc, sp); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (mem[24] !== 8'h11 || write_count != base) $display("[TB] FAIL abort_mem got mem=%h writes=%0d want mem=11 writes=0", mem[24], write_count - base); else passed++;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_push_add();
    test_jumps();
    test_logic_pop();
    test_overflow();
    test_pc_wrap_empty_pop();
    test_reset_mid_pop();
    total++; if (exp_q.size() != 0) $display("[TB] FAIL pending_writes got=%0d want=0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
